// File: rtl/collision_event_manager.sv
// Collision event manager: per-frame collision pulses, score, tower health and game FSM.
// Define HIT_COOLDOWN_EN to ignore tower collisions for COOLDOWN_FRAMES frames after each accepted hit.
module collision_event_manager #(
  parameter int HEALTH_INIT     = 3,
  parameter int SCORE_STEP      = 10,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        startGame,
  input  logic        ShotEnemyCollision,
  input  logic        ShotBoxCollision,
  input  logic        TowerEnemyHUCollision,
  output logic        enemyHitPulse,
  output logic        shotBlockedPulse,
  output logic        towerHitPulse,
  output logic [11:0] score,
  output logic [2:0]  towerHealth,
  output logic        gameActive,
  output logic        gameOver
);

  typedef enum logic [1:0] {IDLE, PLAY, GAMEOVER} state_t;

  state_t state, next_state;

  logic enemy_flag, blocked_flag, tower_flag;
  logic enemy_pulse, blocked_pulse, tower_pulse;
  logic accept_enemy, accept_blocked, accept_tower;
  logic tower_ready;
  logic in_play, enter_play;
  logic [12:0] score_sum;

  assign in_play    = (state == PLAY);
  assign enter_play = (state != PLAY) && startGame;

`ifdef HIT_COOLDOWN_EN
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  logic [CW-1:0] cooldown;

  assign tower_ready = (cooldown == '0);

  // A fresh hit reloads the window even if a frame starts in the same cycle
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cooldown <= '0;
    end else if (enter_play) begin
      cooldown <= '0;
    end else if (in_play && accept_tower) begin
      cooldown <= CW'(COOLDOWN_FRAMES);
    end else if (startOfFrame && (cooldown != '0)) begin
      cooldown <= cooldown - 1'b1;
    end
  end
`else
  logic unused_cooldown_cfg;
  assign unused_cooldown_cfg = (COOLDOWN_FRAMES != 0);
  assign tower_ready = 1'b1;
`endif

  // startOfFrame reopens every flag, so a collision in that cycle belongs to the new frame
  assign accept_enemy   = ShotEnemyCollision && (startOfFrame || !enemy_flag);
  assign accept_blocked = ShotBoxCollision && (startOfFrame || !blocked_flag);
  assign accept_tower   = TowerEnemyHUCollision && tower_ready && (startOfFrame || !tower_flag);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      enemy_flag    <= 1'b0;
      blocked_flag  <= 1'b0;
      tower_flag    <= 1'b0;
      enemy_pulse   <= 1'b0;
      blocked_pulse <= 1'b0;
      tower_pulse   <= 1'b0;
    end else if (!in_play) begin
      enemy_flag    <= 1'b0;
      blocked_flag  <= 1'b0;
      tower_flag    <= 1'b0;
      enemy_pulse   <= 1'b0;
      blocked_pulse <= 1'b0;
      tower_pulse   <= 1'b0;
    end else begin
      enemy_flag    <= (enemy_flag && !startOfFrame) || accept_enemy;
      blocked_flag  <= (blocked_flag && !startOfFrame) || accept_blocked;
      tower_flag    <= (tower_flag && !startOfFrame) || accept_tower;
      enemy_pulse   <= accept_enemy;
      blocked_pulse <= accept_blocked;
      tower_pulse   <= accept_tower;
    end
  end

  // Gating keeps a pulse raised in the last PLAY cycle from leaking into GAMEOVER
  assign enemyHitPulse    = enemy_pulse && in_play;
  assign shotBlockedPulse = blocked_pulse && in_play;
  assign towerHitPulse    = tower_pulse && in_play;

  assign score_sum = {1'b0, score} + 13'(SCORE_STEP);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      score       <= '0;
      towerHealth <= 3'(HEALTH_INIT);
    end else if (enter_play) begin
      score       <= '0;
      towerHealth <= 3'(HEALTH_INIT);
    end else if (in_play) begin
      if (enemyHitPulse) begin
        score <= score_sum[12] ? 12'hFFF : score_sum[11:0];
      end
      if (towerHitPulse && (towerHealth != 3'd0)) begin
        towerHealth <= towerHealth - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (startGame) next_state = PLAY;
      PLAY:     if (towerHealth == 3'd0) next_state = GAMEOVER;
      GAMEOVER: if (startGame) next_state = PLAY;
      default:  next_state = IDLE;
    endcase
  end

  assign gameActive = (state == PLAY);
  assign gameOver   = (state == GAMEOVER);

endmodule

// File: tb/tb_collision_event_manager.sv
// Scoreboard bench for collision_event_manager; expected snapshots are queued with each stimulus step.
// Pass -DHIT_COOLDOWN_EN to both files to exercise the cooldown build.
module tb_collision_event_manager;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        startGame;
  logic        ShotEnemyCollision;
  logic        ShotBoxCollision;
  logic        TowerEnemyHUCollision;
  logic        enemyHitPulse;
  logic        shotBlockedPulse;
  logic        towerHitPulse;
  logic [11:0] score;
  logic [2:0]  towerHealth;
  logic        gameActive;
  logic        gameOver;

  collision_event_manager dut (
    .clk                   (clk),
    .resetN                (resetN),
    .startOfFrame          (startOfFrame),
    .startGame             (startGame),
    .ShotEnemyCollision    (ShotEnemyCollision),
    .ShotBoxCollision      (ShotBoxCollision),
    .TowerEnemyHUCollision (TowerEnemyHUCollision),
    .enemyHitPulse         (enemyHitPulse),
    .shotBlockedPulse      (shotBlockedPulse),
    .towerHitPulse         (towerHitPulse),
    .score                 (score),
    .towerHealth           (towerHealth),
    .gameActive            (gameActive),
    .gameOver              (gameOver)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [11:0] score;
    logic [2:0]  health;
    logic        active;
    logic        over;
    int          enemy;
    int          blocked;
    int          tower;
  } exp_t;

  exp_t sb_q[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int enemy_cnt    = 0;
  int blocked_cnt  = 0;
  int tower_cnt    = 0;
  int base_e, base_b, base_t;

  logic [11:0] model_score;
  logic [2:0]  model_health;
  logic        model_active;
  logic        model_over;

  // Pulses are counted on the falling edge, away from the DUT's update edge
  always @(negedge clk) begin
    if (enemyHitPulse === 1'b1) enemy_cnt++;
    if (shotBlockedPulse === 1'b1) blocked_cnt++;
    if (towerHitPulse === 1'b1) tower_cnt++;
  end

  function automatic logic [11:0] sat_add(input logic [11:0] a);
    int s;
    s = int'(a) + 10;
    return (s > 4095) ? 12'd4095 : 12'(s);
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic mark();
    base_e = enemy_cnt;
    base_b = blocked_cnt;
    base_t = tower_cnt;
  endtask

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int de, input int db, input int dt);
    exp_t e;
    e.tag     = tag;
    e.score   = model_score;
    e.health  = model_health;
    e.active  = model_active;
    e.over    = model_over;
    e.enemy   = de;
    e.blocked = db;
    e.tower   = dt;
    sb_q.push_back(e);
  endtask

  task automatic check_output();
    exp_t e;
    if (sb_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries, expected 1");
    end else begin
      e = sb_q.pop_front();
      compare({e.tag, ".score"}, 32'(score), 32'(e.score));
      compare({e.tag, ".health"}, 32'(towerHealth), 32'(e.health));
      compare({e.tag, ".active"}, 32'(gameActive), 32'(e.active));
      compare({e.tag, ".over"}, 32'(gameOver), 32'(e.over));
      compare({e.tag, ".enemy_pulses"}, 32'(enemy_cnt - base_e), 32'(e.enemy));
      compare({e.tag, ".blocked_pulses"}, 32'(blocked_cnt - base_b), 32'(e.blocked));
      compare({e.tag, ".tower_pulses"}, 32'(tower_cnt - base_t), 32'(e.tower));
    end
  endtask

  // One frame: startOfFrame on the first cycle only, collisions held for the frame
  task automatic apply_stimulus(input int cycles, input logic sof, input logic se,
                                input logic sb, input logic te, input logic te_first_only);
    for (int i = 0; i < cycles; i++) begin
      startOfFrame          = sof && (i == 0);
      ShotEnemyCollision    = se;
      ShotBoxCollision      = sb;
      TowerEnemyHUCollision = te && (!te_first_only || (i == 0));
      step();
    end
    startOfFrame          = 1'b0;
    ShotEnemyCollision    = 1'b0;
    ShotBoxCollision      = 1'b0;
    TowerEnemyHUCollision = 1'b0;
  endtask

  task automatic pulse_start();
    startGame = 1'b1;
    step();
    startGame = 1'b0;
    idle(2);
  endtask

  initial begin
    resetN                = 1'b0;
    startOfFrame          = 1'b0;
    startGame             = 1'b0;
    ShotEnemyCollision    = 1'b0;
    ShotBoxCollision      = 1'b0;
    TowerEnemyHUCollision = 1'b0;
    model_score  = 12'd0;
    model_health = 3'd3;
    model_active = 1'b0;
    model_over   = 1'b0;

    idle(2);
    mark();
    push_exp("reset", 0, 0, 0);
    check_output();

    resetN = 1'b1;
    step();

    // Collisions in IDLE must be ignored
    mark();
    apply_stimulus(50, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    push_exp("idle_enemy", 0, 0, 0);
    check_output();

    mark();
    pulse_start();
    model_active = 1'b1;
    push_exp("start", 0, 0, 0);
    check_output();

    mark();
    apply_stimulus(200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    model_score = sat_add(model_score);
    push_exp("frame1_enemy", 1, 0, 0);
    check_output();

    mark();
    apply_stimulus(200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    model_score = sat_add(model_score);
    push_exp("frame2_enemy", 1, 0, 0);
    check_output();

    mark();
    apply_stimulus(30, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    model_score = sat_add(model_score);
    push_exp("frame3_mixed", 1, 1, 0);
    check_output();

    mark();
    apply_stimulus(4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);
    model_health = 3'd2;
    push_exp("tower_pre_reset", 0, 0, 1);
    check_output();

    // Asynchronous reset mid-cycle, checked before the next clock edge
    mark();
    #1 resetN = 1'b0;
    #1;
    model_score  = 12'd0;
    model_health = 3'd3;
    model_active = 1'b0;
    push_exp("async_reset", 0, 0, 0);
    check_output();

    ShotEnemyCollision = 1'b1;
    step();
    resetN = 1'b1;
    mark();
    idle(3);
    ShotEnemyCollision = 1'b0;
    push_exp("reset_release", 0, 0, 0);
    check_output();

    mark();
    pulse_start();
    model_active = 1'b1;
    push_exp("restart", 0, 0, 0);
    check_output();

    // Saturation: 409 single-hit frames, then more hits past the ceiling
    mark();
    for (int i = 0; i < 409; i++) begin
      apply_stimulus(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      model_score = sat_add(model_score);
    end
    idle(3);
    push_exp("score_4090", 409, 0, 0);
    check_output();

    mark();
    apply_stimulus(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    model_score = sat_add(model_score);
    push_exp("score_sat", 1, 0, 0);
    check_output();

    mark();
    apply_stimulus(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    model_score = sat_add(sat_add(model_score));
    push_exp("score_hold", 2, 0, 0);
    check_output();

`ifdef HIT_COOLDOWN_EN
    mark();
    for (int f = 0; f < 31; f++) begin
      apply_stimulus(3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    idle(2);
    model_health = 3'd2;
    push_exp("cooldown_f0_30", 0, 0, 1);
    check_output();

    mark();
    for (int f = 31; f < 40; f++) begin
      apply_stimulus(3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    idle(2);
    model_health = 3'd1;
    push_exp("cooldown_f31_39", 0, 0, 1);
    check_output();
`else
    mark();
    startOfFrame          = 1'b1;
    TowerEnemyHUCollision = 1'b1;
    step();
    startOfFrame          = 1'b0;
    TowerEnemyHUCollision = 1'b0;
    compare("tower_pulse_next_cycle", 32'(towerHitPulse), 32'd1);
    idle(3);
    model_health = 3'd2;
    push_exp("tower_hit1", 0, 0, 1);
    check_output();

    mark();
    apply_stimulus(3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);
    model_health = 3'd1;
    push_exp("tower_hit2", 0, 0, 1);
    check_output();

    mark();
    apply_stimulus(3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);
    model_health = 3'd0;
    model_active = 1'b0;
    model_over   = 1'b1;
    push_exp("tower_hit3_gameover", 0, 0, 1);
    check_output();

    mark();
    apply_stimulus(20, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3);
    push_exp("gameover_frozen", 0, 0, 0);
    check_output();

    mark();
    pulse_start();
    model_score  = 12'd0;
    model_health = 3'd3;
    model_active = 1'b1;
    model_over   = 1'b0;
    push_exp("replay", 0, 0, 0);
    check_output();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/collision_event_manager.md
COLLISION_EVENT_MANAGER -- requirements
Module: collision_event_manager

Interface
REQ-001 Parameter HEALTH_INIT, default 3: tower health loaded at game start (1..7).
REQ-002 Parameter SCORE_STEP, default 10: score increment per enemy hit.
REQ-003 Parameter COOLDOWN_FRAMES, default 30: invulnerability length in frames (used only under REQ-026).
REQ-004 clk  in  1  system clock; the block's only clock.
REQ-005 resetN  in  1  asynchronous, active-low reset.
REQ-006 startOfFrame  in  1  one-clk pulse at each frame start (30Hz).
REQ-007 startGame  in  1  one-clk start request pulse.
REQ-008 ShotEnemyCollision  in  1  raw per-pixel shot/enemy overlap, level.
REQ-009 ShotBoxCollision  in  1  raw per-pixel shot/tower overlap, level.
REQ-010 TowerEnemyHUCollision  in  1  raw per-pixel tower/enemy overlap, level.
REQ-011 enemyHitPulse  out  1  one-clk pulse per frame with a shot/enemy hit.
REQ-012 shotBlockedPulse  out  1  one-clk pulse per frame with a shot/tower hit.
REQ-013 towerHitPulse  out  1  one-clk pulse per accepted tower hit.
REQ-014 score  out  12  unsigned score.
REQ-015 towerHealth  out  3  remaining tower health.
REQ-016 gameActive  out  1  high in PLAY; gameOver  out  1  high in GAMEOVER.

Function
REQ-017 Each collision input has its own per-frame flag; a pulse is issued the cycle after the first sampled-high input while its flag is clear, and that flag is then set.
REQ-018 All flags clear on startOfFrame; a collision sampled in the same cycle as startOfFrame counts for the new frame (flag set, pulse issued next cycle).
REQ-019 At most one pulse per output per frame, regardless of how many pixels overlap.
REQ-020 FSM states IDLE, PLAY, GAMEOVER; IDLE -> PLAY on startGame; PLAY -> GAMEOVER when towerHealth reaches 0; GAMEOVER -> PLAY on startGame.
REQ-021 Entry to PLAY: score=0, towerHealth=HEALTH_INIT, flags cleared, cooldown counter cleared.
REQ-022 Outside PLAY: all three pulses held 0; score and towerHealth frozen.
REQ-023 In PLAY: enemyHitPulse adds SCORE_STEP to score, saturating at 4095 (no wrap).
REQ-024 In PLAY: towerHitPulse decrements towerHealth by 1; never below 0; the transition to GAMEOVER occurs the cycle after health becomes 0.
REQ-025 shotBlockedPulse has no effect on score or health.

Configuration
REQ-026 With HIT_COOLDOWN_EN defined: after an accepted tower hit, a counter loads COOLDOWN_FRAMES and decrements on each startOfFrame; TowerEnemyHUCollision is ignored (no flag, no pulse) while counter != 0. Without the macro: no counter; the first tower collision of every frame is accepted.

Reset
REQ-027 resetN low asynchronously forces: state IDLE, all flags 0, all pulses 0, score 0, towerHealth HEALTH_INIT, gameActive 0, gameOver 0, cooldown 0.
REQ-028 Reset mid-PLAY abandons the game; no pulse is issued in the cycle after reset release.

Verification
REQ-029 IDLE, ShotEnemyCollision high 50 cycles -> no enemyHitPulse, score 0.
REQ-030 startGame, then ShotEnemyCollision high 200 cycles within one frame -> exactly one enemyHitPulse, score 10; repeat in next frame -> score 20.
REQ-031 startOfFrame and TowerEnemyHUCollision in same cycle (no macro) -> towerHitPulse next cycle, towerHealth 3->2; three such frames -> health 0, gameOver=1, gameActive=0.
REQ-032 Score preset near 4090 via 409 hits, then one more hit -> score 4095, stays 4095 on further hits.
REQ-033 With HIT_COOLDOWN_EN, tower collisions every frame for 40 frames -> hits accepted only at frames 0 and 31; health 3->1.
REQ-034 resetN pulsed low mid-PLAY with score 30 -> score 0, state IDLE, towerHealth 3 immediately, without waiting for clk.
